// File: rtl/scrypt_seq_pkg.sv
// rtl/scrypt_seq_pkg.sv - shared widths, FSM state encoding and nonce byte-swap for the scrypt nonce sequencer
package scrypt_seq_pkg;

  localparam int HDR_W   = 608;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;
  localparam int BH_W    = 640;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_HOLD,
    S_DONE
  } state_t;

  // The header carries the nonce little-endian: nonce[7:0] lands in the top byte of the field.
  function automatic logic [NONCE_W-1:0] nonce_bswap(input logic [NONCE_W-1:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

endpackage

// File: rtl/scrypt_target_cmp.sv
// rtl/scrypt_target_cmp.sv - registered 256-bit unsigned hash <= target compare (the CHECK-stage register)
// Ports: clk/reset; load captures hash and the compare result; hash_q/hit_q hold them until the next load.
module scrypt_target_cmp
  import scrypt_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic [HASH_W-1:0] hash_q,
  output logic              hit_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_q <= '0;
      hit_q  <= 1'b0;
    end else if (load) begin
      hash_q <= hash;
      hit_q  <= (hash <= target);
    end
  end

endmodule

// File: rtl/scrypt_nonce_sequencer.sv
// rtl/scrypt_nonce_sequencer.sv - walks a nonce range through the scrypt core and returns hashes at or below target
// Ports: job_* offer a job (job_ready when idle); blockheader/start/valid_in/scrypt_ready/outScrypt/valid_out
// hook straight onto scrypt_newdp; hit_* is a one-entry valid/ready hit buffer; job_done pulses at job end.
// Optional SCRYPT_SEQ_STATS_EN adds saturating hash_cnt/hit_cnt outputs.
module scrypt_nonce_sequencer
  import scrypt_seq_pkg::*;
#(
  parameter int unsigned SCRYPT_ACK_TIMEOUT = 0
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [HDR_W-1:0]   job_header,
  input  logic [NONCE_W-1:0] job_nonce,
  input  logic [NONCE_W-1:0] job_count,
  input  logic [HASH_W-1:0]  job_target,
  output logic [BH_W-1:0]    blockheader,
  output logic               start,
  output logic               valid_in,
  input  logic               scrypt_ready,
  input  logic [HASH_W-1:0]  outScrypt,
  input  logic               valid_out,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [NONCE_W-1:0] hit_nonce,
  output logic [HASH_W-1:0]  hit_hash,
  output logic               job_done
`ifdef SCRYPT_SEQ_STATS_EN
  ,
  output logic [47:0]        hash_cnt,
  output logic [31:0]        hit_cnt
`endif
);

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] remaining_q;
  logic [HASH_W-1:0]  target_q;
  logic [31:0]        wd_cnt_q;
  logic [HASH_W-1:0]  cmp_hash;
  logic               cmp_hit;
  logic               cmp_load;
  logic               accept;
  logic               hit_take;
  logic               last_nonce;
  logic               advance;
  logic               wd_expire;

  assign accept     = job_valid & job_ready;
  assign hit_take   = hit_valid & hit_ready;
  assign last_nonce = (remaining_q == 32'd1);
  // Results are only accepted while a hash is outstanding; anything else is a stale core output.
  assign cmp_load   = (state_q == S_WAIT) & valid_out;
  assign advance    = ((state_q == S_CHECK) & ~cmp_hit) | ((state_q == S_HOLD) & hit_take);
  assign wd_expire  = (SCRYPT_ACK_TIMEOUT != 0) && (wd_cnt_q == SCRYPT_ACK_TIMEOUT - 32'd1);

  scrypt_target_cmp u_cmp (
    .clk    (clk),
    .reset  (reset),
    .load   (cmp_load),
    .hash   (outScrypt),
    .target (target_q),
    .hash_q (cmp_hash),
    .hit_q  (cmp_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    job_ready = 1'b0;
    start     = 1'b0;
    valid_in  = 1'b0;
    job_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Held low while reset is asserted so no job can be offered into a resetting block.
        job_ready = ~reset;
        if (accept) state_d = (job_count == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (scrypt_ready) begin
          start    = 1'b1;
          valid_in = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (valid_out)      state_d = S_CHECK;
        else if (wd_expire) state_d = S_ISSUE;
      end
      S_CHECK: begin
        if (cmp_hit) state_d = S_HOLD;
        else         state_d = last_nonce ? S_DONE : S_ISSUE;
      end
      S_HOLD: begin
        if (hit_take) state_d = last_nonce ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blockheader <= '0;
      nonce_q     <= '0;
      remaining_q <= '0;
      target_q    <= '0;
      wd_cnt_q    <= '0;
      hit_valid   <= 1'b0;
      hit_nonce   <= '0;
      hit_hash    <= '0;
    end else begin
      if (accept) begin
        blockheader <= {job_header, nonce_bswap(job_nonce)};
        nonce_q     <= job_nonce;
        remaining_q <= job_count;
        target_q    <= job_target;
      end
      if (advance) begin
        nonce_q     <= nonce_q + 32'd1;
        remaining_q <= remaining_q - 32'd1;
        // The finished job's header is left untouched so the field stays stable until the next ISSUE.
        if (!last_nonce) blockheader[NONCE_W-1:0] <= nonce_bswap(nonce_q + 32'd1);
      end
      if (state_q == S_WAIT) wd_cnt_q <= wd_cnt_q + 32'd1;
      else                   wd_cnt_q <= '0;
      if ((state_q == S_CHECK) && cmp_hit) begin
        hit_valid <= 1'b1;
        hit_nonce <= nonce_q;
        hit_hash  <= cmp_hash;
      end else if (hit_take) begin
        hit_valid <= 1'b0;
      end
    end
  end

`ifdef SCRYPT_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_cnt <= '0;
      hit_cnt  <= '0;
    end else if (state_q == S_CHECK) begin
      if (!(&hash_cnt))          hash_cnt <= hash_cnt + 48'd1;
      if (cmp_hit && !(&hit_cnt)) hit_cnt  <= hit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scrypt_nonce_sequencer.sv
// tb/tb_scrypt_nonce_sequencer.sv - directed scoreboard bench for scrypt_nonce_sequencer with a scripted core model
module tb_scrypt_nonce_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [607:0] job_header;
  logic [31:0]  job_nonce;
  logic [31:0]  job_count;
  logic [255:0] job_target;
  logic [639:0] blockheader;
  logic         start;
  logic         valid_in;
  logic         scrypt_ready;
  logic [255:0] outScrypt;
  logic         valid_out;
  logic         hit_valid;
  logic         hit_ready;
  logic [31:0]  hit_nonce;
  logic [255:0] hit_hash;
  logic         job_done;
`ifdef SCRYPT_SEQ_STATS_EN
  logic [47:0]  hash_cnt;
  logic [31:0]  hit_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0]  exp_nonce_q[$];
  logic [287:0] exp_hit_q[$];
  logic [255:0] cur_target;
  logic [607:0] cur_hdr;

  always #5 clk = ~clk;

  scrypt_nonce_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_header   (job_header),
    .job_nonce    (job_nonce),
    .job_count    (job_count),
    .job_target   (job_target),
    .blockheader  (blockheader),
    .start        (start),
    .valid_in     (valid_in),
    .scrypt_ready (scrypt_ready),
    .outScrypt    (outScrypt),
    .valid_out    (valid_out),
    .hit_valid    (hit_valid),
    .hit_ready    (hit_ready),
    .hit_nonce    (hit_nonce),
    .hit_hash     (hit_hash),
    .job_done     (job_done)
`ifdef SCRYPT_SEQ_STATS_EN
    ,
    .hash_cnt     (hash_cnt),
    .hit_cnt      (hit_cnt)
`endif
  );

  function automatic logic [31:0] swap_tb(input logic [31:0] n);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[31-8*b -: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic random_hdr(output logic [607:0] h);
    for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom;
  endtask

  task automatic accept_job(input logic [607:0] hdr, input logic [31:0] nonce,
                            input logic [31:0] count, input logic [255:0] target);
    cur_target = target;
    cur_hdr    = hdr;
    for (int i = 0; i < int'(count); i++) exp_nonce_q.push_back(nonce + 32'(i));
    job_header = hdr;
    job_nonce  = nonce;
    job_count  = count;
    job_target = target;
    job_valid  = 1'b1;
    chk("job_ready_at_offer", 640'(job_ready), 640'(1'b1));
    tick();
    job_valid  = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("start_timeout", 640'(start), 640'(1'b1));
  endtask

  task automatic pop_nonce(output logic [31:0] n);
    if (exp_nonce_q.size() == 0) begin
      chk("unexpected_start", 640'(exp_nonce_q.size()), 640'(1));
      n = '0;
    end else begin
      n = exp_nonce_q.pop_front();
    end
  endtask

  // Core model: waits for a start, checks the issued header against the scoreboard, returns hash after lat cycles.
  task automatic issue_and_return(input logic [255:0] hash, input int lat);
    bit          ok;
    logic [31:0] n;
    wait_start(ok);
    if (ok) begin
      pop_nonce(n);
      chk("nonce_field", 640'(blockheader[31:0]), 640'(swap_tb(n)));
      chk("hdr_field", 640'(blockheader[639:32]), 640'(cur_hdr));
      chk("valid_in_with_start", 640'(valid_in), 640'(1'b1));
      tick();
      chk("start_one_cycle", 640'(start), 640'(1'b0));
      repeat (lat - 1) tick();
      valid_out = 1'b1;
      outScrypt = hash;
      tick();
      valid_out = 1'b0;
      outScrypt = '0;
      if (hash <= cur_target) exp_hit_q.push_back({n, hash});
    end
  endtask

  // Called in the CHECK cycle; ends one cycle after the nonce retires (next ISSUE or DONE).
  task automatic finish_nonce(input bit last, input int stall);
    logic [287:0] e;
    tick();
    if (exp_hit_q.size() > 0) begin
      e = exp_hit_q.pop_front();
      chk("hit_valid", 640'(hit_valid), 640'(1'b1));
      chk("hit_nonce", 640'(hit_nonce), 640'(e[287:256]));
      chk("hit_hash", 640'(hit_hash), 640'(e[255:0]));
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("hit_hold", 640'({hit_valid, hit_nonce, hit_hash}), 640'({1'b1, e}));
        chk("no_start_in_hold", 640'(start), 640'(1'b0));
      end
      hit_ready = 1'b1;
      tick();
      hit_ready = 1'b0;
      chk("hit_cleared", 640'(hit_valid), 640'(1'b0));
    end else begin
      chk("no_hit", 640'(hit_valid), 640'(1'b0));
    end
    if (last) begin
      chk("job_done", 640'(job_done), 640'(1'b1));
      tick();
      chk("job_done_pulse", 640'(job_done), 640'(1'b0));
      chk("job_ready_after_done", 640'(job_ready), 640'(1'b1));
    end else begin
      chk("next_start", 640'(start), 640'(1'b1));
    end
  endtask

  initial begin
    logic [607:0] hdr;
    logic [255:0] t;
    logic [31:0]  n;
    bit           ok;
    bit           early;

    reset        = 1'b1;
    job_valid    = 1'b0;
    job_header   = '0;
    job_nonce    = '0;
    job_count    = '0;
    job_target   = '0;
    scrypt_ready = 1'b1;
    outScrypt    = '0;
    valid_out    = 1'b0;
    hit_ready    = 1'b0;
    repeat (3) tick();

    chk("rst_job_ready", 640'(job_ready), 640'(1'b0));
    chk("rst_ctrl", 640'({start, valid_in, hit_valid, job_done}), 640'(4'b0));
    chk("rst_blockheader", blockheader, 640'(0));
    chk("rst_hit_data", 640'({hit_nonce, hit_hash}), 640'(0));
    reset = 1'b0;
    tick();
    chk("idle_job_ready", 640'(job_ready), 640'(1'b1));

    // Basic miss run
    random_hdr(hdr);
    accept_job(hdr, 32'h0000_0010, 32'd3, 256'd0);
    chk("start_at_accept_plus1", 640'(start), 640'(1'b1));
    chk("first_nonce_field", 640'(blockheader[31:0]), 640'(32'h1000_0000));
    for (int i = 0; i < 3; i++) begin
      issue_and_return({$urandom, $urandom, 192'd0} | 256'd1, 4);
      finish_nonce(i == 2, 0);
    end

    // Hit with backpressure, last nonce also a hit
    random_hdr(hdr);
    accept_job(hdr, 32'h0000_0100, 32'd2, {256{1'b1}});
    issue_and_return({$urandom, 224'd5}, 3);
    finish_nonce(1'b0, 5);
    issue_and_return({$urandom, 224'd9}, 2);
    finish_nonce(1'b1, 0);

    // Nonce wrap-around
    random_hdr(hdr);
    accept_job(hdr, 32'hFFFF_FFFF, 32'd2, 256'd0);
    issue_and_return(256'd77, 2);
    finish_nonce(1'b0, 0);
    chk("wrapped_nonce_field", 640'(blockheader[31:0]), 640'(32'h0000_0000));
    issue_and_return(256'd78, 2);
    finish_nonce(1'b1, 0);

    // Zero count
    random_hdr(hdr);
    accept_job(hdr, 32'h1234_5678, 32'd0, 256'd0);
    chk("zero_no_start", 640'(start), 640'(1'b0));
    chk("zero_job_done", 640'(job_done), 640'(1'b1));
    tick();
    chk("zero_job_ready", 640'(job_ready), 640'(1'b1));
    chk("zero_done_pulse", 640'(job_done), 640'(1'b0));

    // Stray result in IDLE, then core not ready for 10 cycles with another stray result
    valid_out = 1'b1;
    outScrypt = '0;
    tick();
    valid_out = 1'b0;
    chk("stray_idle_no_hit", 640'(hit_valid), 640'(1'b0));
    chk("stray_idle_ready", 640'(job_ready), 640'(1'b1));
    scrypt_ready = 1'b0;
    random_hdr(hdr);
    accept_job(hdr, 32'h0000_0055, 32'd1, {1'b1, 255'd0});
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (start !== 1'b0) early = 1'b1;
      valid_out = (i == 4);
      tick();
    end
    valid_out = 1'b0;
    chk("start_held_off", 640'(early), 640'(1'b0));
    scrypt_ready = 1'b1;
    #1;
    chk("start_on_ready", 640'(start), 640'(1'b1));
    issue_and_return({256{1'b1}}, 2);
    finish_nonce(1'b1, 0);

    // Equality boundary: hash == target hits, target + 1 misses
    t = {1'b0, $urandom, $urandom, $urandom, 159'd3};
    random_hdr(hdr);
    accept_job(hdr, 32'h0000_0200, 32'd2, t);
    issue_and_return(t, 3);
    finish_nonce(1'b0, 1);
    issue_and_return(t + 256'd1, 3);
    finish_nonce(1'b1, 0);
    chk("nonce_sb_drained", 640'(exp_nonce_q.size()), 640'(0));
    chk("hit_sb_drained", 640'(exp_hit_q.size()), 640'(0));

    // Reset mid-job with a hit arriving in the reset cycle and a late result afterwards
    random_hdr(hdr);
    accept_job(hdr, 32'h0000_0300, 32'd3, {256{1'b1}});
    wait_start(ok);
    pop_nonce(n);
    chk("rstjob_nonce_field", 640'(blockheader[31:0]), 640'(swap_tb(n)));
    tick();
    tick();
    reset     = 1'b1;
    valid_out = 1'b1;
    outScrypt = '0;
    tick();
    valid_out = 1'b0;
    chk("midrst_ctrl", 640'({start, valid_in, hit_valid, job_done, job_ready}), 640'(5'b0));
    chk("midrst_blockheader", blockheader, 640'(0));
    chk("midrst_hit_data", 640'({hit_nonce, hit_hash}), 640'(0));
    exp_nonce_q.delete();
    reset     = 1'b0;
    valid_out = 1'b1;
    tick();
    valid_out = 1'b0;
    chk("postrst_job_ready", 640'(job_ready), 640'(1'b1));
    tick();
    chk("postrst_no_hit", 640'({hit_valid, start}), 640'(2'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
